pmem_burst_adaptor: RTL and testbench

//  Sits directly downstream of the cache controller's physical-memory port.

---
 rtl/pmem_burst_adaptor_if.sv | 39 +++
 rtl/pmem_burst_adaptor.sv | 136 +++++++++++++
 tb/tb_pmem_burst_adaptor.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_burst_adaptor_if.sv
// Bus bundle for pmem_burst_adaptor: cache-side line port plus memory-side burst port.
// The slave modport is the adaptor's view; master is the cache/memory environment's view.
interface pmem_burst_adaptor_if #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned LINE_W = BEATS * BEAT_W;

  // Cache-side line port
  logic [ADDR_W-1:0] line_addr_i;
  logic              line_read_i;
  logic              line_write_i;
  logic [LINE_W-1:0] line_wdata_i;
  logic [LINE_W-1:0] line_rdata_o;
  logic              line_resp_o;

  // Memory-side burst port
  logic [ADDR_W-1:0] burst_addr_o;
  logic              burst_read_o;
  logic              burst_write_o;
  logic [BEAT_W-1:0] burst_wdata_o;
  logic [BEAT_W-1:0] burst_rdata_i;
  logic              burst_resp_i;

  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o,
    output burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o,
    input  burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o
  );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: turns one cacheline read/write request into a BEATS-long burst
// on the memory bus, gathering read beats into a line and splitting a write line into beats,
// then answers the cache with a single-cycle line response.
// Optional feature macro: PMEM_BURST_TIMEOUT_EN adds an inter-beat idle timeout that
// forces completion and raises a sticky timeout_o flag.
module pmem_burst_adaptor #(
  parameter int unsigned BEATS   = 4,
  parameter int unsigned BEAT_W  = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  pmem_burst_adaptor_if.slave  bus
`ifdef PMEM_BURST_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  localparam int unsigned LINE_W = BEATS * BEAT_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte-offset bits within a line; cleared to form the line-aligned burst address.
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wbuf_q;
  logic [LINE_W-1:0] rdata_q;

  logic in_burst;
  logic beat_acc;
  logic beat_last;
  logic accept;
  logic idle_expire;

  assign in_burst  = (state_q == StRead) || (state_q == StWrite);
  assign beat_acc  = in_burst && bus.burst_resp_i;
  assign beat_last = (cnt_q == CNT_W'(BEATS - 1));
  assign accept    = (state_q == StIdle) && (bus.line_write_i || bus.line_read_i);

  // Offset bits of the incoming address are dropped on purpose.
  logic unused_addr_off;
  assign unused_addr_off = ^bus.line_addr_i[OFF_W-1:0];

`ifdef PMEM_BURST_TIMEOUT_EN
  logic [7:0] idle_q;
  logic       timeout_q;

  assign idle_expire = in_burst && !bus.burst_resp_i && (idle_q == 8'(TIMEOUT));
  assign timeout_o   = timeout_q;

  // Idle counter between beats; sticky flag once a burst is abandoned for silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_burst || bus.burst_resp_i) begin
        idle_q <= 8'd0;
      end else begin
        idle_q <= idle_q + 8'd1;
      end
      if (idle_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign idle_expire = 1'b0;
`endif

  // Next-state logic; write wins when both requests are present.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.line_write_i) begin
          state_d = StWrite;
        end else if (bus.line_read_i) begin
          state_d = StRead;
        end
      end
      StRead, StWrite: begin
        if ((beat_acc && beat_last) || idle_expire) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context capture at accept, beat counting and read-line assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q <= {bus.line_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
      wbuf_q <= bus.line_wdata_i;
      cnt_q  <= '0;
    end else if (beat_acc) begin
      cnt_q <= beat_last ? '0 : cnt_q + CNT_W'(1);
      if (state_q == StRead) begin
        rdata_q[cnt_q*BEAT_W +: BEAT_W] <= bus.burst_rdata_i;
      end
    end
  end

  // Moore outputs decoded from state only.
  assign bus.burst_read_o  = (state_q == StRead);
  assign bus.burst_write_o = (state_q == StWrite);
  assign bus.line_resp_o   = (state_q == StDone);
  assign bus.burst_addr_o  = addr_q;
  assign bus.line_rdata_o  = rdata_q;
  assign bus.burst_wdata_o = (state_q == StWrite) ? wbuf_q[cnt_q*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: stimulus pushes expected bursts, write beats and
// line responses into queues; a monitor pops and compares as the DUT presents them.
module tb_pmem_burst_adaptor;

  typedef logic [255:0] line_t;
  typedef logic [63:0]  beat_t;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
  } burst_exp_t;

  typedef struct {
    bit    is_read;
    line_t rdata;
    int    lat;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef PMEM_BURST_TIMEOUT_EN
  logic timeout;
`endif

  pmem_burst_adaptor_if #(.BEATS(4), .BEAT_W(64), .ADDR_W(32)) bus ();

  pmem_burst_adaptor #(
    .BEATS  (4),
    .BEAT_W (64),
    .ADDR_W (32),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PMEM_BURST_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  int resp_count = 0;

  burst_exp_t burst_q[$];
  resp_exp_t  resp_q[$];
  beat_t      wbeat_q[$];

  // Memory model: 0 = zero-wait, 1 = resp gated 0-1-0-1, 2 = never respond.
  int    mode = 0;
  bit    phase = 1'b0;
  int    mem_beat = 0;
  beat_t mem_data[4];
  line_t last_line = '0;

  task automatic check(input string name, input line_t act, input line_t exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    fails++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: drives beats away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.burst_resp_i  = 1'b0;
      bus.burst_rdata_i = '0;
      phase = 1'b0;
    end else if (bus.burst_read_o || bus.burst_write_o) begin
      case (mode)
        0: bus.burst_resp_i = 1'b1;
        1: begin
          bus.burst_resp_i = phase;
          phase = ~phase;
        end
        default: bus.burst_resp_i = 1'b0;
      endcase
      bus.burst_rdata_i = mem_data[mem_beat];
    end else begin
      bus.burst_resp_i = 1'b0;
      phase = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) mem_beat = 0;
    else if (bus.burst_resp_i && bus.burst_read_o) mem_beat = (mem_beat + 1) % 4;
  end

  // Monitor / scoreboard.
  bit        prev_req = 1'b0;
  int        start_cyc = 0;
  always begin
    burst_exp_t be;
    resp_exp_t  re;
    bit         req;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      req = bus.burst_read_o | bus.burst_write_o;
      if (bus.burst_read_o && bus.burst_write_o) fail_now("rd_wr_both_high");
      if (req && !prev_req) begin
        start_cyc = cyc;
        if (burst_q.size() == 0) fail_now("unexpected_burst");
        else begin
          be = burst_q.pop_front();
          check("burst_kind_is_write", line_t'(bus.burst_write_o), line_t'(be.is_write));
          check("burst_addr", line_t'(bus.burst_addr_o), line_t'(be.addr));
        end
      end
      prev_req = req;
      if (bus.burst_write_o) begin
        if (wbeat_q.size() == 0) fail_now("extra_write_beat");
        else begin
          check("burst_wdata", line_t'(bus.burst_wdata_o), line_t'(wbeat_q[0]));
          if (bus.burst_resp_i) void'(wbeat_q.pop_front());
        end
      end
      if (bus.line_resp_o) begin
        resp_count++;
        if (resp_q.size() == 0) fail_now("unexpected_line_resp");
        else begin
          re = resp_q.pop_front();
          if (re.lat >= 0) check("resp_latency", line_t'(cyc - start_cyc), line_t'(re.lat));
          if (re.is_read) check("line_rdata", bus.line_rdata_o, re.rdata);
        end
      end
    end
  end

  task automatic wait_resp();
    int seen = resp_count;
    int n = 0;
    while (resp_count == seen && n < 600) begin
      @(posedge clk);
      #8;
      n++;
    end
    if (resp_count == seen) fail_now("line_resp_timeout");
  endtask

  // Issue one line request (caller sits at a negedge), hold until response, drop next cycle.
  task automatic do_line(input bit wr, input bit rd, input logic [31:0] addr, input line_t wl,
                         input line_t exp_rd, input int lat);
    burst_exp_t b;
    resp_exp_t  r;
    b.is_write = wr;
    b.addr     = {addr[31:5], 5'b0};
    burst_q.push_back(b);
    if (wr) for (int i = 0; i < 4; i++) wbeat_q.push_back(wl[i*64 +: 64]);
    r.is_read = !wr;
    r.rdata   = exp_rd;
    r.lat     = lat;
    resp_q.push_back(r);
    if (!wr) last_line = exp_rd;
    bus.line_addr_i  = addr;
    bus.line_wdata_i = wl;
    bus.line_write_i = wr;
    bus.line_read_i  = rd;
    wait_resp();
    @(negedge clk);
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
  endtask

  function automatic line_t mem_line();
    return {mem_data[3], mem_data[2], mem_data[1], mem_data[0]};
  endfunction

  initial begin
    burst_exp_t b;
    line_t      wl;
    int         n;
    bus.line_addr_i  = '0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_wdata_i = '0;
    bus.burst_rdata_i = '0;
    bus.burst_resp_i  = 1'b0;
    for (int i = 0; i < 4; i++) mem_data[i] = '0;

    // Reset state
    #3;
    check("rst_burst_read", line_t'(bus.burst_read_o), '0);
    check("rst_burst_write", line_t'(bus.burst_write_o), '0);
    check("rst_line_resp", line_t'(bus.line_resp_o), '0);
    check("rst_burst_addr", line_t'(bus.burst_addr_o), '0);
    check("rst_line_rdata", bus.line_rdata_o, '0);
    check("rst_burst_wdata", line_t'(bus.burst_wdata_o), '0);
`ifdef PMEM_BURST_TIMEOUT_EN
    check("rst_timeout", line_t'(timeout), '0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait read
    mode = 0;
    mem_data[0] = 64'h1111_1111_1111_1111;
    mem_data[1] = 64'h2222_2222_2222_2222;
    mem_data[2] = 64'h3333_3333_3333_3333;
    mem_data[3] = 64'h4444_4444_4444_4444;
    do_line(1'b0, 1'b1, 32'h0000_1234, '0, mem_line(), 4);
    @(negedge clk);

    // 2: gated write, beats D,C,B,A
    mode = 1;
    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_line(1'b1, 1'b0, 32'h8000_0047, wl, '0, 8);
    mode = 0;
    @(negedge clk);

    // 3: read and write together -> write only
    wl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
          64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    do_line(1'b1, 1'b1, 32'h0000_2468, wl, '0, 4);
    check("rdata_stable_after_write", bus.line_rdata_o, last_line);
    @(negedge clk);

    // 4: reset after beat 2 of a read
    mem_data[0] = 64'h9999_0000_0000_0001;
    mem_data[1] = 64'h9999_0000_0000_0002;
    mem_data[2] = 64'h9999_0000_0000_0003;
    mem_data[3] = 64'h9999_0000_0000_0004;
    b.is_write = 1'b0;
    b.addr     = 32'h0000_3300;
    burst_q.push_back(b);
    bus.line_addr_i = 32'h0000_3310;
    bus.line_read_i = 1'b1;
    n = 0;
    while (mem_beat < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mem_beat < 2) fail_now("abandoned_read_beats");
    @(negedge clk);
    #3;
    rst = 1'b1;
    bus.line_read_i = 1'b0;
    #1;
    check("midrst_burst_read", line_t'(bus.burst_read_o), '0);
    check("midrst_line_resp", line_t'(bus.line_resp_o), '0);
    check("midrst_burst_addr", line_t'(bus.burst_addr_o), '0);
    check("midrst_line_rdata", bus.line_rdata_o, '0);
    @(negedge clk);
    rst = 1'b0;
    last_line = '0;
    repeat (2) @(negedge clk);
    mem_data[0] = 64'h0123_4567_89AB_CDEF;
    mem_data[1] = 64'hFEDC_BA98_7654_3210;
    mem_data[2] = 64'h5A5A_5A5A_A5A5_A5A5;
    mem_data[3] = 64'hC3C3_3C3C_0F0F_F0F0;
    do_line(1'b0, 1'b1, 32'h0000_3310, '0, mem_line(), 4);
    @(negedge clk);

    // 5: back-to-back write then read
    wl = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
          64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};
    do_line(1'b1, 1'b0, 32'h0001_0000, wl, '0, 4);
    mem_data[0] = 64'hE1E1_E1E1_E1E1_E1E1;
    mem_data[1] = 64'hE2E2_E2E2_E2E2_E2E2;
    mem_data[2] = 64'hE3E3_E3E3_E3E3_E3E3;
    mem_data[3] = 64'hE4E4_E4E4_E4E4_E4E4;
    do_line(1'b0, 1'b1, 32'h0001_0020, '0, mem_line(), 4);
    repeat (10) @(negedge clk);

`ifdef PMEM_BURST_TIMEOUT_EN
    // 6: silent memory -> timeout completion, prior line retained
    check("timeout_before", line_t'(timeout), '0);
    mode = 2;
    do_line(1'b0, 1'b1, 32'h0002_0000, '0, last_line, 256);
    check("timeout_set", line_t'(timeout), 1);
    repeat (5) @(negedge clk);
    check("timeout_sticky", line_t'(timeout), 1);
    mode = 0;
    rst = 1'b1;
    #1;
    check("timeout_cleared", line_t'(timeout), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("burst_q_drained", line_t'(burst_q.size()), '0);
    check("resp_q_drained", line_t'(resp_q.size()), '0);
    check("wbeat_q_drained", line_t'(wbeat_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
